alu_issue_ctrl: RTL and testbench

//  Producer side of the ALU operand/control interface. Decodes a MIPS instruction plus its register

---
 rtl/alu_pkg.sv | 66 ++++++
 rtl/alu_issue_decode.sv | 104 ++++++++++
 rtl/alu_issue_ctrl.sv | 104 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, MIPS opcode/funct constants and the
// issue-buffer entry layout used by alu_issue_decode and alu_issue_ctrl.
package alu_pkg;

    localparam int ALU_DW = 32;
    localparam int ALU_CW = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1101;
    localparam logic [3:0] ALU_SRL = 4'b1110;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef struct packed {
        logic [ALU_DW-1:0] data_a;
        logic [ALU_DW-1:0] data_b;
        logic [ALU_DW-1:0] imme;
        logic              alu_src;
        logic [ALU_CW-1:0] alu_control;
        logic [4:0]        shamt;
        logic              illegal;
    } alu_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    // Value an entry register holds out of reset: all zero except the NOP code.
    function automatic alu_entry_t alu_entry_reset();
        alu_entry_t e;
        e             = '0;
        e.alu_control = ALU_NOP;
        return e;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Pure combinational MIPS instruction -> ALU issue entry decoder.
// Optional build macro SHIFT_VAR_EN adds sllv/srlv (shift amount from rs_data).
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [ALU_DW-1:0] rs_data,
    input  logic [ALU_DW-1:0] rt_data,
    output alu_entry_t        entry
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [ALU_DW-1:0] imm_sext;
    logic [ALU_DW-1:0] imm_zext;
    logic              unused_reg_fields;

    assign op       = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'h0000, instr[15:0]};
    // Register specifiers were consumed by the regfile read upstream.
    assign unused_reg_fields = ^instr[25:16];

    always_comb begin
        // Default is the illegal encoding; each legal case clears the flag.
        entry             = '0;
        entry.data_a      = rs_data;
        entry.data_b      = rt_data;
        entry.alu_control = ALU_NOP;
        entry.illegal     = 1'b1;
        case (op)
            OP_RTYPE: begin
                entry.illegal = 1'b0;
                case (funct)
                    F_ADD, F_ADDU: entry.alu_control = ALU_ADD;
                    F_SUB, F_SUBU: entry.alu_control = ALU_SUB;
                    F_AND:         entry.alu_control = ALU_AND;
                    F_OR:          entry.alu_control = ALU_OR;
                    F_NOR:         entry.alu_control = ALU_NOR;
                    F_SLTU:        entry.alu_control = ALU_SLT;
                    F_SLL: begin
                        entry.alu_control = ALU_SLL;
                        entry.shamt       = instr[10:6];
                    end
                    F_SRL: begin
                        entry.alu_control = ALU_SRL;
                        entry.shamt       = instr[10:6];
                    end
`ifdef SHIFT_VAR_EN
                    F_SLLV: begin
                        entry.alu_control = ALU_SLL;
                        entry.shamt       = rs_data[4:0];
                    end
                    F_SRLV: begin
                        entry.alu_control = ALU_SRL;
                        entry.shamt       = rs_data[4:0];
                    end
`endif
                    default: entry.illegal = 1'b1;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW: begin
                entry.illegal     = 1'b0;
                entry.alu_src     = 1'b1;
                entry.imme        = imm_sext;
                entry.alu_control = ALU_ADD;
            end
            OP_SLTIU: begin
                entry.illegal     = 1'b0;
                entry.alu_src     = 1'b1;
                entry.imme        = imm_sext;
                entry.alu_control = ALU_SLT;
            end
            OP_ANDI: begin
                entry.illegal     = 1'b0;
                entry.alu_src     = 1'b1;
                entry.imme        = imm_zext;
                entry.alu_control = ALU_AND;
            end
            OP_ORI: begin
                entry.illegal     = 1'b0;
                entry.alu_src     = 1'b1;
                entry.imme        = imm_zext;
                entry.alu_control = ALU_OR;
            end
            OP_LUI: begin
                entry.illegal     = 1'b0;
                entry.alu_src     = 1'b1;
                entry.imme        = {instr[15:0], 16'h0000};
                entry.data_a      = '0;
                entry.alu_control = ALU_OR;
            end
            OP_BEQ, OP_BNE: begin
                // Compare rs against rt; the offset rides along for the branch unit.
                entry.illegal     = 1'b0;
                entry.imme        = imm_sext;
                entry.alu_control = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ID-stage operands and hands them to EX through a
// 2-entry valid/ready skid buffer. Build macro SHIFT_VAR_EN enables sllv/srlv decode.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW     = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DW-1:0]     rs_data,
    input  logic [DW-1:0]     rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     data_a,
    output logic [DW-1:0]     data_b,
    output logic [DW-1:0]     imme,
    output logic              ALUSrc,
    output logic [CTRL_W-1:0] alu_control,
    output logic [4:0]        shamt,
    output logic              illegal
);

    buf_state_t state_q, state_d;
    alu_entry_t head_q, head_d;
    alu_entry_t skid_q, skid_d;
    alu_entry_t dec_entry;
    logic       acc;
    logic       pop;

    alu_issue_decode u_decode (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .entry   (dec_entry)
    );

    // Both handshake qualifiers come from state, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    head_d  = dec_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    head_d = dec_entry;
                end else if (acc) begin
                    skid_d  = dec_entry;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= alu_entry_reset();
            skid_q  <= alu_entry_reset();
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign data_a      = head_q.data_a;
    assign data_b      = head_q.data_b;
    assign imme        = head_q.imme;
    assign ALUSrc      = head_q.alu_src;
    assign alu_control = head_q.alu_control;
    assign shamt       = head_q.shamt;
    assign illegal     = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed vectors push expected entries on accept,
// a negedge monitor compares the head whenever out_valid is high.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] instr, rs_data, rt_data;
    logic [31:0] data_a, data_b, imme;
    logic        alu_src, illegal;
    logic [3:0]  alu_control;
    logic [4:0]  shamt;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DW(32), .CTRL_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_a      (data_a),
        .data_b      (data_b),
        .imme        (imme),
        .ALUSrc      (alu_src),
        .alu_control (alu_control),
        .shamt       (shamt),
        .illegal     (illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        alu_entry_t  exp;
    } vec_t;

    alu_entry_t sb_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic src, input logic [3:0] c, input logic [4:0] sh,
                                input logic ill);
        vec_t v;
        v.instr           = i;
        v.rs              = rs;
        v.rt              = rt;
        v.exp.data_a      = a;
        v.exp.data_b      = b;
        v.exp.imme        = imm;
        v.exp.alu_src     = src;
        v.exp.alu_control = c;
        v.exp.shamt       = sh;
        v.exp.illegal     = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic alu_entry_t cur_out();
        alu_entry_t g;
        g.data_a      = data_a;
        g.data_b      = data_b;
        g.imme        = imme;
        g.alu_src     = alu_src;
        g.alu_control = alu_control;
        g.shamt       = shamt;
        g.illegal     = illegal;
        return g;
    endfunction

    // Monitor: one comparison per cycle the head is presented; pop on handshake.
    always @(negedge clk) begin
        alu_entry_t got;
        if (rst || flush) begin
            sb_q.delete();
        end else if (out_valid) begin
            got = cur_out();
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got %0h expected no output", got);
            end else begin
                check("sb_entry", 128'(got), 128'(sb_q[0]));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic drive(input bit v, input vec_t vv, input bit fl, input bit rdy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        instr     = vv.instr;
        rs_data   = vv.rs;
        rt_data   = vv.rt;
        flush     = fl;
        out_ready = rdy;
        @(negedge clk);
        acc = v && in_ready && !fl && !rst;
        if (acc) sb_q.push_back(vv.exp);
    endtask

    vec_t v_idle, v_addu, v_addiu, v_andi, v_lui, v_sll, v_sub, v_or, v_nor, v_and;
    vec_t v_ill, v_sllv, v_sltu;
    alu_entry_t rst_exp;
    bit   acc;
    int   n_acc;

    initial begin
        v_idle  = mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'hF, 5'd0, 1'b0);
        v_addu  = mk(32'h00221821, 32'd5, 32'd7, 32'd5, 32'd7, 32'h0, 1'b0, 4'b0010, 5'd0, 1'b0);
        v_addiu = mk(32'h2422FFFF, 32'h100, 32'h200, 32'h100, 32'h200, 32'hFFFFFFFF, 1'b1, 4'b0010, 5'd0, 1'b0);
        v_andi  = mk(32'h3022FFFF, 32'h100, 32'h200, 32'h100, 32'h200, 32'h0000FFFF, 1'b1, 4'b0000, 5'd0, 1'b0);
        v_lui   = mk(32'h3C021234, 32'h55, 32'h66, 32'h0, 32'h66, 32'h12340000, 1'b1, 4'b0001, 5'd0, 1'b0);
        v_sll   = mk(32'h00021900, 32'h8, 32'h3, 32'h8, 32'h3, 32'h0, 1'b0, 4'b1101, 5'd4, 1'b0);
        v_sub   = mk(32'h00221823, 32'd9, 32'd4, 32'd9, 32'd4, 32'h0, 1'b0, 4'b0110, 5'd0, 1'b0);
        v_or    = mk(32'h00221825, 32'hF0, 32'h0F, 32'hF0, 32'h0F, 32'h0, 1'b0, 4'b0001, 5'd0, 1'b0);
        v_nor   = mk(32'h00221827, 32'h1, 32'h2, 32'h1, 32'h2, 32'h0, 1'b0, 4'b1100, 5'd0, 1'b0);
        v_and   = mk(32'h00221824, 32'hAA, 32'hCC, 32'hAA, 32'hCC, 32'h0, 1'b0, 4'b0000, 5'd0, 1'b0);
        v_sltu  = mk(32'h0022182B, 32'h1, 32'h2, 32'h1, 32'h2, 32'h0, 1'b0, 4'b0111, 5'd0, 1'b0);
        v_ill   = mk(32'hFC000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'b1111, 5'd0, 1'b1);
`ifdef SHIFT_VAR_EN
        v_sllv  = mk(32'h00221804, 32'd3, 32'h10, 32'd3, 32'h10, 32'h0, 1'b0, 4'b1101, 5'd3, 1'b0);
`else
        v_sllv  = mk(32'h00221804, 32'd3, 32'h10, 32'd3, 32'h10, 32'h0, 1'b0, 4'b1111, 5'd0, 1'b1);
`endif
        rst_exp = v_idle.exp;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_data = '0; rt_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_outputs", 128'(cur_out()), 128'(rst_exp));
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single addu, one-cycle latency
        drive(1'b1, v_addu, 1'b0, 1'b1, acc);
        check("t1_accept", 128'(acc), 128'(1));
        drive(1'b0, v_idle, 1'b0, 1'b1, acc);
        check("t1_latency", 128'(out_valid), 128'(1));
        drive(1'b0, v_idle, 1'b0, 1'b1, acc);
        check("t1_drained", 128'(out_valid), 128'(0));

        // 2: immediate extension, back-to-back at full rate
        drive(1'b1, v_addiu, 1'b0, 1'b1, acc); check("t2_acc0", 128'(acc), 128'(1));
        drive(1'b1, v_andi,  1'b0, 1'b1, acc); check("t2_acc1", 128'(acc), 128'(1));
        drive(1'b1, v_lui,   1'b0, 1'b1, acc); check("t2_acc2", 128'(acc), 128'(1));
        drive(1'b1, v_sll,   1'b0, 1'b1, acc); check("t2_acc3", 128'(acc), 128'(1));
        repeat (2) drive(1'b0, v_idle, 1'b0, 1'b1, acc);
        check("t2_all_emitted", 128'(sb_q.size()), 128'(0));

        // 3: stall with three offers, then release
        n_acc = 0;
        drive(1'b1, v_sub, 1'b0, 1'b0, acc); n_acc += int'(acc);
        drive(1'b1, v_or,  1'b0, 1'b0, acc); n_acc += int'(acc);
        drive(1'b1, v_nor, 1'b0, 1'b0, acc); n_acc += int'(acc);
        check("t3_in_ready_full", 128'(in_ready), 128'(0));
        check("t3_accepted", 128'(n_acc), 128'(2));
        repeat (3) drive(1'b0, v_idle, 1'b0, 1'b0, acc);
        repeat (3) drive(1'b0, v_idle, 1'b0, 1'b1, acc);
        check("t3_all_emitted", 128'(sb_q.size()), 128'(0));
        check("t3_drained", 128'(out_valid), 128'(0));

        // 4: flush while FULL with a same-cycle offer
        drive(1'b1, v_sub, 1'b0, 1'b0, acc);
        drive(1'b1, v_or,  1'b0, 1'b0, acc);
        drive(1'b1, v_and, 1'b1, 1'b1, acc);
        drive(1'b0, v_idle, 1'b0, 1'b1, acc);
        check("t4_out_valid", 128'(out_valid), 128'(0));
        check("t4_in_ready", 128'(in_ready), 128'(1));
        repeat (2) drive(1'b0, v_idle, 1'b0, 1'b1, acc);
        check("t4_nothing_emitted", 128'(out_valid), 128'(0));

        // 5: illegal encoding and sllv
        drive(1'b1, v_ill,  1'b0, 1'b1, acc); check("t5_acc0", 128'(acc), 128'(1));
        drive(1'b1, v_sllv, 1'b0, 1'b1, acc); check("t5_acc1", 128'(acc), 128'(1));
        repeat (2) drive(1'b0, v_idle, 1'b0, 1'b1, acc);
        check("t5_all_emitted", 128'(sb_q.size()), 128'(0));

        // 6: reset while one entry is held
        drive(1'b1, v_sltu, 1'b0, 1'b0, acc);
        drive(1'b0, v_idle, 1'b0, 1'b0, acc);
        check("t6_holding", 128'(out_valid), 128'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_out_valid", 128'(out_valid), 128'(0));
        check("t6_in_ready", 128'(in_ready), 128'(1));
        check("t6_outputs", 128'(cur_out()), 128'(rst_exp));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
